// File: rtl/mcycle_muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mcycle_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam logic SIGNED = 1'b1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mcycle_muldiv_signfix.sv
// Conditional two's-complement negation: operand abs() on entry, result sign-fix on exit.
// With i_wide set the pair {i_b,i_a} is negated as one double-width value (product).
module mcycle_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_neg_a,
  input  logic         i_neg_b,
  input  logic         i_wide,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);

  logic [2*W-1:0] w_cat;
  logic [2*W-1:0] w_cat_neg;
  logic [W-1:0]   w_a_neg;
  logic [W-1:0]   w_b_neg;

  assign w_cat     = {i_b, i_a};
  assign w_cat_neg = -w_cat;
  assign w_a_neg   = -i_a;
  assign w_b_neg   = -i_b;

  always_comb begin
    o_a = i_a;
    o_b = i_b;
    if (i_wide) begin
      if (i_neg_a) {o_b, o_a} = w_cat_neg;
    end else begin
      if (i_neg_a) o_a = w_a_neg;
      if (i_neg_b) o_b = w_b_neg;
    end
  end

endmodule

// File: rtl/mcycle_muldiv.sv
// Radix-2 multi-cycle multiply / restoring divide. Busy stalls the PC; Done pulses
// once when Result1/Result2 are updated. Latency is WIDTH+1 cycles for every op.
module mcycle_muldiv
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_neg_q, r_neg_r, r_dbz;
  // r_hi/r_lo: {partial high, multiplier} for MUL, {remainder, dividend->quotient} for DIV
  logic [WIDTH-1:0]   r_hi, r_lo, r_b;
  logic [WIDTH-1:0]   r_res1, r_res2;

  logic               w_sgn, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_sum, w_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;
  logic [WIDTH-1:0]   w_fix_a, w_fix_b;

  assign w_sgn  = (MCycleOp[0] == SIGNED);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  mcycle_signfix #(.W(WIDTH)) u_entry (
    .i_a     (Operand1),
    .i_b     (Operand2),
    .i_neg_a (w_sgn & Operand1[WIDTH-1]),
    .i_neg_b (w_sgn & Operand2[WIDTH-1]),
    .i_wide  (1'b0),
    .o_a     (w_abs_a),
    .o_b     (w_abs_b)
  );

  // One iteration of either algorithm
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_b});
  assign w_sub = w_sh[WIDTH-1:0] - r_b;

  always_comb begin
    if (r_div) begin
      w_hi_nxt = w_ge ? w_sub : w_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  mcycle_signfix #(.W(WIDTH)) u_exit (
    .i_a     (w_lo_nxt),
    .i_b     (w_hi_nxt),
    .i_neg_a (r_neg_q),
    .i_neg_b (r_neg_r),
    .i_wide  (~r_div),
    .o_a     (w_fix_a),
    .o_b     (w_fix_b)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start)  w_state_nxt = COMPUTE;
      COMPUTE: if (w_last) w_state_nxt = DONE;
      DONE:                w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  // Busy is gated by Reset so an abort drops the stall immediately
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      IDLE:    Busy = Start & Reset;
      COMPUTE: Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_cnt   <= '0;
          r_div   <= (MCycleOp[1] == OP_DIV);
          r_neg_q <= w_sgn & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
          r_neg_r <= w_sgn & MCycleOp[1] & Operand1[WIDTH-1];
          r_dbz   <= MCycleOp[1] & (Operand2 == '0);
          r_hi    <= '0;
          r_lo    <= MCycleOp[1] ? w_abs_a : w_abs_b;
          r_b     <= MCycleOp[1] ? w_abs_b : w_abs_a;
        end
        COMPUTE: begin
          r_cnt <= r_cnt + 1'b1;
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          // Divide-by-zero: the restoring loop already leaves |dividend| as the
          // remainder, and sign-fix turns it back into the raw dividend.
          if (w_last) begin
            r_res1 <= r_dbz ? '1 : w_fix_a;
            r_res2 <= w_fix_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result1 = r_res1;
  assign Result2 = r_res2;

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Self-checking bench for mcycle_muldiv: vector table through a result scoreboard,
// plus hand-written sequences for hold-through-DONE, back-to-back and mid-op reset.
module tb_mcycle_muldiv;
  localparam int W = 32;

  logic          CLK, Reset, Start;
  logic [1:0]    MCycleOp;
  logic [W-1:0]  Operand1, Operand2, Result1, Result2;
  logic          Busy, Done;

  int n_chk = 0;
  int n_fail = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, e1, e2;
  } vec_t;
  vec_t tbl[12];

  mcycle_muldiv #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one op in the current IDLE cycle, tracks Busy/Done, checks against the scoreboard.
  // With hold=1, Start stays high through the DONE cycle edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2, input bit hold);
    int busy_cnt, done_cyc;
    logic [2*W-1:0] exp;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    sb.push_back({e2, e1});
    #1;
    check("busy_cycle0", Busy, 1);
    busy_cnt = Busy ? 1 : 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      @(negedge CLK);
      if (Busy) busy_cnt++;
      if (Done) begin done_cyc = cyc; break; end
      if (!hold) Start = 1'b0;
      MCycleOp = 2'($urandom);
      Operand1 = $urandom;
      Operand2 = $urandom;
    end
    if (done_cyc == 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no Done within %0d cycles", W + 6);
    end
    check("done_cycle", done_cyc, W + 1);
    check("busy_cycles", busy_cnt, W + 1);
    exp = sb.pop_front();
    check("result1", Result1, exp[W-1:0]);
    check("result2", Result2, exp[2*W-1:W]);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    tbl[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 32'hFFFFFFFF};
    tbl[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2};
    tbl[4]  = '{2'b11, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000};
    tbl[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    tbl[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[7]  = '{2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
    tbl[8]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    tbl[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    tbl[10] = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001};
    tbl[11] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};

    Reset = 1'b0; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_result1", Result1, 0);
    check("rst_result2", Result2, 0);
    @(negedge CLK); Reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e1, tbl[i].e2, 1'b0);

    // Start held through DONE must not retrigger
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    @(negedge CLK);
    Start = 1'b0;
    #1;
    check("idle_after_done_busy", Busy, 0);
    check("idle_after_done_done", Done, 0);
    @(negedge CLK);
    check("no_retrigger_busy", Busy, 0);

    // Back-to-back: second op starts in the IDLE cycle right after DONE
    run_op(2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b1);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);

    // Reset at cycle 10 of a divide aborts with everything cleared at once
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'd1000; Operand2 = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge CLK);
    check("pre_abort_busy", Busy, 1);
    Reset = 1'b0; Start = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_result1", Result1, 0);
    check("abort_result2", Result2, 0);
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1;

    run_op(2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
